// File: rtl/axi_sram_resp.sv
// Single-beat AXI read/write responder backed by an on-chip word array.
// Read and write FSMs run independently and may respond in the same cycle.
module axi_sram_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(4 * DEPTH_WORDS);
    localparam logic [15:0] RD_CNT_INIT = 16'(RD_LAT - 2);
    localparam logic [15:0] WR_CNT_INIT = 16'(WR_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_COMMIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // Burst/length errors take priority over address decode errors.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic [7:0] len,
                                               input logic [1:0] burst, input logic last);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        if (len != 8'd0 || burst != 2'b00 || !last) return 2'b10;
        if (addr < ADDR_BASE || off >= SPAN) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return IDX_W'(off >> 2);
    endfunction

    logic unused_sizes;
    assign unused_sizes = ^{arsize, awsize};

    r_state_t    r_state, r_next;
    logic [31:0] r_addr_q;
    logic [1:0]  r_resp_q;
    logic [15:0] r_cnt;
    logic        r_capture;
    logic [31:0] r_src_addr;
    logic [1:0]  r_src_resp;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign rlast   = 1'b1;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = (RD_LAT == 1) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_cnt == 16'd0) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        r_capture  = (r_next == R_RESP) && (r_state != R_RESP);
        r_src_addr = (r_state == R_IDLE) ? araddr : r_addr_q;
        r_src_resp = (r_state == R_IDLE) ? decode_resp(araddr, arlen, arburst, 1'b1) : r_resp_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Response fields are registered once on entry to R_RESP so they stay stable while stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_q <= '0;
            r_resp_q <= '0;
            r_cnt    <= '0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                r_addr_q <= araddr;
                r_resp_q <= decode_resp(araddr, arlen, arburst, 1'b1);
                r_cnt    <= RD_CNT_INIT;
                rid      <= arid;
            end else if (r_state == R_WAIT && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (r_capture) begin
                rresp <= r_src_resp;
                rdata <= (r_src_resp == 2'b00) ? mem[word_index(r_src_addr)] : 32'd0;
            end
        end
    end

    w_state_t    w_state, w_next;
    logic [31:0] aw_addr_q, wd_q;
    logic [7:0]  aw_len_q;
    logic [1:0]  aw_burst_q;
    logic [3:0]  aw_id_q, ws_q;
    logic        wl_q;
    logic [15:0] w_cnt;
    logic        c_go, c_last;
    logic [31:0] c_addr, c_data;
    logic [7:0]  c_len;
    logic [1:0]  c_burst, c_resp;
    logic [3:0]  c_id, c_strb;

    assign awready = (w_state == W_IDLE) || (w_state == W_ADDR);
    assign wready  = (w_state == W_IDLE) || (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);

    // Commit source mux: each half comes either live from the bus or from its holding register.
    always_comb begin
        w_next  = w_state;
        c_go    = 1'b0;
        c_addr  = awaddr;
        c_len   = awlen;
        c_burst = awburst;
        c_id    = awid;
        c_data  = wdata;
        c_strb  = wstrb;
        c_last  = wlast;
        case (w_state)
            W_IDLE: begin
                c_go = awvalid && wvalid;
                if (awvalid && wvalid) w_next = W_COMMIT;
                else if (awvalid)      w_next = W_DATA;
                else if (wvalid)       w_next = W_ADDR;
            end
            W_DATA: begin
                c_go    = wvalid;
                c_addr  = aw_addr_q;
                c_len   = aw_len_q;
                c_burst = aw_burst_q;
                c_id    = aw_id_q;
                if (wvalid) w_next = W_COMMIT;
            end
            W_ADDR: begin
                c_go   = awvalid;
                c_data = wd_q;
                c_strb = ws_q;
                c_last = wl_q;
                if (awvalid) w_next = W_COMMIT;
            end
            W_COMMIT: if (w_cnt == 16'd0) w_next = W_RESP;
            W_RESP:   if (bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
        c_resp = decode_resp(c_addr, c_len, c_burst, c_last);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
            aw_id_q    <= '0;
            wd_q       <= '0;
            ws_q       <= '0;
            wl_q       <= 1'b0;
            w_cnt      <= '0;
            bid        <= '0;
            bresp      <= '0;
        end else begin
            if (w_state == W_IDLE && awvalid) begin
                aw_addr_q  <= awaddr;
                aw_len_q   <= awlen;
                aw_burst_q <= awburst;
                aw_id_q    <= awid;
            end
            if (w_state == W_IDLE && wvalid) begin
                wd_q <= wdata;
                ws_q <= wstrb;
                wl_q <= wlast;
            end
            if (c_go) begin
                bid   <= c_id;
                bresp <= c_resp;
                w_cnt <= WR_CNT_INIT;
            end else if (w_state == W_COMMIT && w_cnt != 16'd0) begin
                w_cnt <= w_cnt - 16'd1;
            end
        end
    end

    // Array is not reset; a write lands on the edge that enters W_COMMIT.
    always_ff @(posedge clock) begin
        if (reset && c_go && c_resp == 2'b00) begin
            for (int b = 0; b < 4; b++) begin
                if (c_strb[b]) mem[word_index(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_resp.sv
// Scoreboard bench for axi_sram_resp: drivers push expected R/B responses,
// a negedge monitor compares every cycle a response is presented.
module tb_axi_sram_resp;

    logic        clock, reset;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, wstrb, bid;
    logic [31:0] awaddr, wdata;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs_cyc;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     r_seen = 0;

    axi_sram_resp dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: whenever a response is valid it must match the head expectation, every cycle it is held.
    always @(negedge clock) begin
        if (reset && rvalid) begin
            if (rq.size() == 0) begin
                check_output("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check_output("rid", 32'(rid), 32'(rq[0].id));
                check_output("rdata", rdata, rq[0].data);
                check_output("rresp", 32'(rresp), 32'(rq[0].resp));
                check_output("rlast", 32'(rlast), 32'd1);
                if (!r_seen) begin
                    check_output("r_latency", 32'(cyc - rq[0].hs_cyc), 32'd1);
                    r_seen = 1;
                end
                if (rready) begin
                    void'(rq.pop_front());
                    r_seen = 0;
                end
            end
        end
        if (reset && bvalid) begin
            if (bq.size() == 0) begin
                check_output("unexpected_bvalid", 32'd1, 32'd0);
            end else begin
                check_output("bid", 32'(bid), 32'(bq[0].id));
                check_output("bresp", 32'(bresp), 32'(bq[0].resp));
                if (bready) void'(bq.pop_front());
            end
        end
    end

    task automatic read_word(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        r_exp_t e;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!arready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!arready) begin
            check_output("ar_handshake_timeout", 32'd0, 32'd1);
        end else begin
            e.id = id; e.data = exp_data; e.resp = exp_resp; e.hs_cyc = cyc;
            rq.push_back(e);
        end
        @(posedge clock);
        #1 arvalid = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic last, input int aw_delay,
                              input int w_delay, input logic [1:0] exp_resp);
        b_exp_t e;
        e.id = id; e.resp = exp_resp;
        bq.push_back(e);
        fork
            begin
                int n;
                repeat (aw_delay) @(posedge clock);
                if (aw_delay > 0) #1;
                awid = id; awaddr = addr; awlen = 8'd0; awburst = 2'b00; awsize = 3'd2; awvalid = 1'b1;
                n = 0;
                @(negedge clock);
                while (!awready && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                if (!awready) check_output("aw_handshake_timeout", 32'd0, 32'd1);
                @(posedge clock);
                #1 awvalid = 1'b0;
            end
            begin
                int n;
                repeat (w_delay) @(posedge clock);
                if (w_delay > 0) #1;
                wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
                n = 0;
                @(negedge clock);
                while (!wready && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                if (!wready) check_output("w_handshake_timeout", 32'd0, 32'd1);
                @(posedge clock);
                #1 wvalid = 1'b0;
            end
        join
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clock);
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_output("drain", 32'(rq.size() + bq.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus();
        // Reset mid-response: response is dropped and never reappears.
        rready = 1'b0;
        read_word(4'h3, 32'h7FFF_FFFC, 8'd0, 2'b00, 32'd0, 2'b11);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_output("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check_output("rst_mid_arready", 32'(arready), 32'd1);
        rq.delete();
        r_seen = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        rready = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_output("no_rvalid_after_reset", 32'(rvalid), 32'd0);
        @(posedge clock);
        #1;

        // Full-word write then read back; partial byte-lane update.
        write_word(4'h1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b1, 0, 0, 2'b00);
        wait_drain();
        read_word(4'h2, 32'h8000_0004, 8'd0, 2'b00, 32'hDEAD_BEEF, 2'b00);
        wait_drain();
        write_word(4'h4, 32'h8000_0004, 32'h00AB_0000, 4'b0100, 1'b1, 0, 0, 2'b00);
        wait_drain();
        read_word(4'h6, 32'h8000_0004, 8'd0, 2'b00, 32'hDEAB_BEEF, 2'b00);
        wait_drain();

        // Split AW/W arrival in both orders with stalled responders.
        bready = 1'b0;
        write_word(4'h5, 32'h8000_0008, 32'h1111_1111, 4'b1111, 1'b1, 0, 3, 2'b00);
        repeat (6) @(posedge clock);
        #1 bready = 1'b1;
        wait_drain();
        bready = 1'b0;
        write_word(4'h5, 32'h8000_000C, 32'h2222_2222, 4'b1111, 1'b1, 3, 0, 2'b00);
        repeat (6) @(posedge clock);
        #1 bready = 1'b1;
        wait_drain();
        rready = 1'b0;
        read_word(4'h7, 32'h8000_0008, 8'd0, 2'b00, 32'h1111_1111, 2'b00);
        repeat (5) @(posedge clock);
        #1 rready = 1'b1;
        wait_drain();
        read_word(4'h8, 32'h8000_000C, 8'd0, 2'b00, 32'h2222_2222, 2'b00);
        wait_drain();

        // Error responses; the out-of-range write would alias word 0 if not blocked.
        read_word(4'h9, 32'h7FFF_FFFC, 8'd0, 2'b00, 32'd0, 2'b11);
        wait_drain();
        read_word(4'hA, 32'h8000_0000, 8'd1, 2'b00, 32'd0, 2'b10);
        wait_drain();
        read_word(4'hB, 32'h8000_0004, 8'd0, 2'b01, 32'd0, 2'b10);
        wait_drain();
        write_word(4'h2, 32'h8000_0000, 32'h1234_5678, 4'b1111, 1'b1, 0, 0, 2'b00);
        wait_drain();
        write_word(4'h3, 32'h9000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 0, 0, 2'b11);
        wait_drain();
        write_word(4'h4, 32'h8000_0004, 32'h0000_0000, 4'b1111, 1'b0, 0, 0, 2'b10);
        wait_drain();
        read_word(4'hC, 32'h8000_0000, 8'd0, 2'b00, 32'h1234_5678, 2'b00);
        wait_drain();
        read_word(4'hD, 32'h8000_0004, 8'd0, 2'b00, 32'hDEAB_BEEF, 2'b00);
        wait_drain();

        // Read capture and write commit on the same edge: old data first, new data after.
        write_word(4'h6, 32'h8000_0010, 32'hAAAA_0001, 4'b1111, 1'b1, 0, 0, 2'b00);
        wait_drain();
        fork
            read_word(4'hE, 32'h8000_0010, 8'd0, 2'b00, 32'hAAAA_0001, 2'b00);
            write_word(4'h7, 32'h8000_0010, 32'hBBBB_0002, 4'b1111, 1'b1, 0, 0, 2'b00);
        join
        wait_drain();
        read_word(4'hF, 32'h8000_0010, 8'd0, 2'b00, 32'hBBBB_0002, 2'b00);
        wait_drain();
    endtask

    initial begin
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = '0;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b1;
        rready = 1'b1; bready = 1'b1;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        check_output("rst_arready", 32'(arready), 32'd1);
        check_output("rst_awready", 32'(awready), 32'd1);
        check_output("rst_wready", 32'(wready), 32'd1);
        check_output("rst_rvalid", 32'(rvalid), 32'd0);
        check_output("rst_bvalid", 32'(bvalid), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_rid", 32'(rid), 32'd0);
        check_output("rst_rresp", 32'(rresp), 32'd0);
        check_output("rst_rlast", 32'(rlast), 32'd1);
        check_output("rst_bid", 32'(bid), 32'd0);
        check_output("rst_bresp", 32'(bresp), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
